// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: steps through the digit slots,
// holds a one-cycle dead time per slot and swaps in a new value only at frame boundaries.
module display_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic [3:0]  digit,
  output logic [3:0]  anode_n,
  output logic        frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] TC_VAL = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   display_q, display_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    anode_q, anode_d;
  logic          frame_done_q, frame_done_d;
  logic          tc, wrap, blank;

  always_comb begin
    tc           = (presc_q == TC_VAL);
    wrap         = tc && (idx_q == 2'd3);
    presc_d      = tc ? '0 : presc_q + 1'b1;
    idx_d        = tc ? idx_q + 2'd1 : idx_q;
    shadow_d     = load ? value_in : shadow_q;
    // A load coinciding with the wrap goes straight to the display so it is not lost.
    display_d    = display_q;
    if (wrap) display_d = load ? value_in : shadow_q;
    // Outputs are derived from the post-edge state so they line up with presc/idx.
    digit_d      = display_d[{idx_d, 2'b00} +: 4];
    blank        = BLANK_LZ && (idx_d != 2'd0) && ((display_d >> {idx_d, 2'b00}) == 16'h0);
    anode_d      = 4'hF;
    if ((presc_d != '0) && !blank) anode_d = ~(4'b0001 << idx_d);
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0;
      display_q    <= 16'h0;
      digit_q      <= 4'h0;
      anode_q      <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      digit_q      <= digit_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit      = digit_q;
  assign anode_n    = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: two instances (blanking on/off) share stimulus; each slot is
// checked cycle by cycle against hand-computed digit/anode/frame_done values.
module tb_display_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit, anode_n, digit0, anode_n0;
  logic        frame_done, frame_done0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
    .digit(digit), .anode_n(anode_n), .frame_done(frame_done));

  display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
    .digit(digit0), .anode_n(anode_n0), .frame_done(frame_done0));

  // Never more than one digit enabled, on either instance.
  always @(negedge clk) begin
    tests++;
    assert ($countones(~anode_n) <= 1 && $countones(~anode_n0) <= 1) else begin
      fails++;
      $error("FAIL onehot anode_n=%h anode_n0=%h required at most one low bit", anode_n, anode_n0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered at the dead cycle of a slot; leaves at the dead cycle of the next one.
  // ldf pulses load on the first edge of the slot, ldl on the last (slot-exit) edge.
  task automatic slot(input string tag, input logic [3:0] d, input logic [3:0] an,
                      input logic [3:0] an0, input logic fd,
                      input bit ldf, input bit ldl, input logic [15:0] ldv);
    chk({tag, " dead anode"}, anode_n, 4'hF);
    chk({tag, " dead anode0"}, anode_n0, 4'hF);
    chk({tag, " dead digit"}, digit, d);
    chk({tag, " dead digit0"}, digit0, d);
    chk({tag, " frame_done"}, {3'b0, frame_done}, {3'b0, fd});
    chk({tag, " frame_done0"}, {3'b0, frame_done0}, {3'b0, fd});
    if (ldf) begin value_in = ldv; load = 1'b1; end
    for (int c = 1; c < 4; c++) begin
      step();
      load = 1'b0;
      chk($sformatf("%s c%0d anode", tag, c), anode_n, an);
      chk($sformatf("%s c%0d anode0", tag, c), anode_n0, an0);
      chk($sformatf("%s c%0d digit", tag, c), digit, d);
      chk($sformatf("%s c%0d fd", tag, c), {3'b0, frame_done}, 4'h0);
    end
    if (ldl) begin value_in = ldv; load = 1'b1; end
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value_in = 16'h0;
    step(); step();
    chk("rst anode", anode_n, 4'hF);
    chk("rst digit", digit, 4'h0);
    chk("rst fd", {3'b0, frame_done}, 4'h0);
    rst_n = 1'b1;

    // Free run, display 0: slots 1-3 blanked on the blanking instance
    slot("A0", 4'h0, 4'hE, 4'hE, 1'b0, 0, 0, 16'h0);
    slot("A1", 4'h0, 4'hF, 4'hD, 1'b0, 0, 0, 16'h0);
    slot("A2", 4'h0, 4'hF, 4'hB, 1'b0, 0, 0, 16'h0);
    slot("A3", 4'h0, 4'hF, 4'h7, 1'b0, 0, 0, 16'h0);
    // Load 12A4 mid-frame; must not show until next frame
    slot("B0", 4'h0, 4'hE, 4'hE, 1'b1, 1, 0, 16'h12A4);
    slot("B1", 4'h0, 4'hF, 4'hD, 1'b0, 0, 0, 16'h0);
    slot("B2", 4'h0, 4'hF, 4'hB, 1'b0, 0, 0, 16'h0);
    slot("B3", 4'h0, 4'hF, 4'h7, 1'b0, 0, 0, 16'h0);
    slot("C0", 4'h4, 4'hE, 4'hE, 1'b1, 0, 0, 16'h0);
    slot("C1", 4'hA, 4'hD, 4'hD, 1'b0, 0, 0, 16'h0);
    slot("C2", 4'h2, 4'hB, 4'hB, 1'b0, 1, 0, 16'h0050);
    slot("C3", 4'h1, 4'h7, 4'h7, 1'b0, 0, 0, 16'h0);
    // 0050: upper two slots blanked only when blanking is enabled
    slot("D0", 4'h0, 4'hE, 4'hE, 1'b1, 1, 0, 16'h1234);
    slot("D1", 4'h5, 4'hD, 4'hD, 1'b0, 0, 0, 16'h0);
    slot("D2", 4'h0, 4'hF, 4'hB, 1'b0, 0, 0, 16'h0);
    slot("D3", 4'h0, 4'hF, 4'h7, 1'b0, 0, 0, 16'h0);
    // No tear: FFFF loaded during slot 2 of the 1234 frame
    slot("E0", 4'h4, 4'hE, 4'hE, 1'b1, 0, 0, 16'h0);
    slot("E1", 4'h3, 4'hD, 4'hD, 1'b0, 0, 0, 16'h0);
    slot("E2", 4'h2, 4'hB, 4'hB, 1'b0, 1, 0, 16'hFFFF);
    slot("E3", 4'h1, 4'h7, 4'h7, 1'b0, 0, 0, 16'h0);
    // Shadow gets 1111, then BEEF arrives exactly on the wrap edge
    slot("F0", 4'hF, 4'hE, 4'hE, 1'b1, 0, 0, 16'h0);
    slot("F1", 4'hF, 4'hD, 4'hD, 1'b0, 1, 0, 16'h1111);
    slot("F2", 4'hF, 4'hB, 4'hB, 1'b0, 0, 0, 16'h0);
    slot("F3", 4'hF, 4'h7, 4'h7, 1'b0, 0, 1, 16'hBEEF);
    slot("G0", 4'hF, 4'hE, 4'hE, 1'b1, 0, 0, 16'h0);
    slot("G1", 4'hE, 4'hD, 4'hD, 1'b0, 0, 0, 16'h0);
    // Reset for one cycle mid slot 2, with a load that must be ignored
    step();
    chk("G2 anode", anode_n, 4'hB);
    chk("G2 digit", digit, 4'hE);
    rst_n = 1'b0; load = 1'b1; value_in = 16'h9999;
    step();
    chk("midrst anode", anode_n, 4'hF);
    chk("midrst digit", digit, 4'h0);
    chk("midrst fd", {3'b0, frame_done}, 4'h0);
    rst_n = 1'b1; load = 1'b0;
    slot("R0", 4'h0, 4'hE, 4'hE, 1'b0, 0, 0, 16'h0);
    slot("R1", 4'h0, 4'hF, 4'hD, 1'b0, 0, 0, 16'h0);
    slot("R2", 4'h0, 4'hF, 4'hB, 1'b0, 0, 0, 16'h0);
    slot("R3", 4'h0, 4'hF, 4'h7, 1'b0, 0, 0, 16'h0);
    // Second frame after reset: shadow must have been cleared
    slot("S0", 4'h0, 4'hE, 4'hE, 1'b1, 0, 0, 16'h0);
    slot("S1", 4'h0, 4'hF, 4'hD, 1'b0, 0, 0, 16'h0);
    slot("S2", 4'h0, 4'hF, 4'hB, 1'b0, 0, 0, 16'h0);
    slot("S3", 4'h0, 4'hF, 4'h7, 1'b0, 0, 0, 16'h0);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
